// File: rtl/wav_ahb_pkg.sv
// Shared AHB-Lite encodings and manager state type.
// Used by the single-transfer AHB manager and its bench.
package wav_ahb_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] SIZE_BYTE  = 3'b000;
  localparam logic [2:0] SIZE_HALF  = 3'b001;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [2:0] SIZE_DWORD = 3'b011;

  localparam logic [2:0] BURST_SINGLE = 3'b000;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_ERR2 = 2'd2
  } mgr_state_e;

endpackage

// File: rtl/wav_ahb_manager.sv
// AHB-Lite single-transfer manager with one address phase
// overlapping one data phase; two-cycle error handling.
module wav_ahb_manager
  import wav_ahb_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              i_hclk,
  input  logic              i_hresetn,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [2:0]        i_req_size,
  input  logic [AWIDTH-1:0] i_req_addr,
  input  logic [DWIDTH-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DWIDTH-1:0] o_rsp_rdata,
  output logic              o_rsp_error,
  output logic [AWIDTH-1:0] o_haddr,
  output logic              o_hwrite,
  output logic [2:0]        o_hsize,
  output logic [2:0]        o_hburst,
  output logic [1:0]        o_htrans,
  output logic [DWIDTH-1:0] o_hwdata,
  input  logic [DWIDTH-1:0] i_hrdata,
  input  logic              i_hready,
  input  logic [1:0]        i_hresp
);

  mgr_state_e        state;
  logic              dp_valid;
  logic              dp_write;
  logic              cxl;
  logic              cxl_rsp;
  logic [DWIDTH-1:0] wdata_q;

  logic hresp_err;
  logic accept;
  logic addr_done;
  logic dp_done;
  logic err_start;

  assign hresp_err = (i_hresp != RESP_OKAY);

  assign o_req_ready = (state != ST_ERR2) &&
                       ((state == ST_IDLE) ||
                        (i_hready && !hresp_err));

  assign accept    = i_req_valid && o_req_ready;
  assign addr_done = (state == ST_ADDR) && i_hready;
  assign dp_done   = dp_valid && i_hready && (state != ST_ERR2);
  assign err_start = dp_valid && hresp_err && !i_hready &&
                     (state != ST_ERR2);

  assign o_htrans = (state == ST_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;
  assign o_hburst = BURST_SINGLE;

  // A pending address phase at error entry is dropped, not replayed
  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      state    <= ST_IDLE;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      cxl      <= 1'b0;
      cxl_rsp  <= 1'b0;
    end else begin
      cxl_rsp <= 1'b0;
      if (err_start) begin
        state <= ST_ERR2;
        cxl   <= (state == ST_ADDR) || accept;
      end else begin
        unique case (1'b1)
          (state == ST_ERR2): begin
            if (i_hready) begin
              state    <= ST_IDLE;
              dp_valid <= 1'b0;
              cxl      <= 1'b0;
              cxl_rsp  <= cxl;
            end
          end
          (state == ST_ADDR): begin
            if (i_hready) begin
              state    <= accept ? ST_ADDR : ST_IDLE;
              dp_valid <= 1'b1;
              dp_write <= o_hwrite;
            end
          end
          default: begin
            if (accept)
              state <= ST_ADDR;
            if (i_hready)
              dp_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      o_haddr  <= '0;
      o_hwrite <= 1'b0;
      o_hsize  <= SIZE_WORD;
      wdata_q  <= '0;
      o_hwdata <= '0;
    end else begin
      if (accept) begin
        o_haddr  <= i_req_addr;
        o_hwrite <= i_req_write;
        o_hsize  <= i_req_size;
        wdata_q  <= i_req_wdata;
      end
      if (addr_done)
        o_hwdata <= wdata_q;
    end
  end

  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_error <= 1'b0;
    end else begin
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_error <= 1'b0;
      if (((state == ST_ERR2) && i_hready) || cxl_rsp) begin
        o_rsp_valid <= 1'b1;
        o_rsp_error <= 1'b1;
      end else if (dp_done) begin
        o_rsp_valid <= 1'b1;
        o_rsp_rdata <= dp_write ? '0 : i_hrdata;
        o_rsp_error <= hresp_err;
      end
    end
  end

endmodule

// File: tb/tb_wav_ahb_manager.sv
// Directed per-cycle vectors for the AHB manager,
// plus a mid-transfer reset sequence.
module tb_wav_ahb_manager;
  import wav_ahb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_size = SIZE_WORD;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic [31:0] hrdata = '0;
  logic        hready = 1'b1;
  logic [1:0]  hresp = RESP_OKAY;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wav_ahb_manager #(.AWIDTH(32), .DWIDTH(32)) dut (
    .i_hclk(clk),
    .i_hresetn(rst_n),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_write(req_write),
    .i_req_size(req_size),
    .i_req_addr(req_addr),
    .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid),
    .o_rsp_rdata(rsp_rdata),
    .o_rsp_error(rsp_error),
    .o_haddr(haddr),
    .o_hwrite(hwrite),
    .o_hsize(hsize),
    .o_hburst(hburst),
    .o_htrans(htrans),
    .o_hwdata(hwdata),
    .i_hrdata(hrdata),
    .i_hready(hready),
    .i_hresp(hresp)
  );

  typedef struct {
    logic        v;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        hr;
    logic [1:0]  rs;
    logic [31:0] rd;
    logic [1:0]  et;
    logic [31:0] ea;
    logic        ew;
    logic [31:0] ed;
    logic        ey;
    logic        ev;
    logic [31:0] erd;
    logic        ee;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    logic v, logic w, logic [31:0] a, logic [31:0] d,
    logic hr, logic [1:0] rs, logic [31:0] rd,
    logic [1:0] et, logic [31:0] ea, logic ew,
    logic [31:0] ed, logic ey, logic ev,
    logic [31:0] erd, logic ee);
    vec_t r;
    r.v = v; r.w = w; r.a = a; r.d = d;
    r.hr = hr; r.rs = rs; r.rd = rd;
    r.et = et; r.ea = ea; r.ew = ew; r.ed = ed;
    r.ey = ey; r.ev = ev; r.erd = erd; r.ee = ee;
    return r;
  endfunction

  task automatic chk(string name, logic [127:0] act,
                     logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] obs();
    return {26'd0, htrans, haddr, hwrite, hwdata,
            req_ready, rsp_valid, rsp_rdata, rsp_error};
  endfunction

  function automatic logic [127:0] reset_vals();
    return {htrans, haddr, hwrite, hsize, hburst, hwdata,
            rsp_valid, rsp_rdata, rsp_error};
  endfunction

  localparam logic [1:0] ID = TRANS_IDLE;
  localparam logic [1:0] NS = TRANS_NONSEQ;
  localparam logic [1:0] OK = RESP_OKAY;
  localparam logic [1:0] ER = RESP_ERROR;
  localparam logic [1:0] RT = RESP_RETRY;

  initial begin
    logic [127:0] rst_exp;
    rst_exp = {1'b0, ID, 32'h0, 1'b0, SIZE_WORD,
               BURST_SINGLE, 32'h0, 1'b0, 32'h0, 1'b0};

    // single write, no wait states
    vq.push_back(mk(1,1,32'h1000,32'hDEADBEEF,1,OK,0, ID,0,0,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0,1,OK,0, NS,32'h1000,1,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0,1,OK,0, ID,32'h1000,1,32'hDEADBEEF,1,0,0,0));
    vq.push_back(mk(0,0,0,0,1,OK,0, ID,32'h1000,1,32'hDEADBEEF,1,1,0,0));
    // three pipelined reads
    vq.push_back(mk(1,0,32'h10,0,1,OK,0, ID,32'h1000,1,32'hDEADBEEF,1,0,0,0));
    vq.push_back(mk(1,0,32'h14,0,1,OK,0, NS,32'h10,0,32'hDEADBEEF,1,0,0,0));
    vq.push_back(mk(1,0,32'h18,0,1,OK,32'h10, NS,32'h14,0,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0,1,OK,32'h14, NS,32'h18,0,0,1,1,32'h10,0));
    vq.push_back(mk(0,0,0,0,1,OK,32'h18, ID,32'h18,0,0,1,1,32'h14,0));
    vq.push_back(mk(0,0,0,0,1,OK,0, ID,32'h18,0,0,1,1,32'h18,0));
    // write with three data-phase wait states
    vq.push_back(mk(1,1,32'h2000,32'h12345678,1,OK,0, ID,32'h18,0,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0,1,OK,0, NS,32'h2000,1,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0,0,OK,0, ID,32'h2000,1,32'h12345678,1,0,0,0));
    vq.push_back(mk(0,0,0,0,0,OK,0, ID,32'h2000,1,32'h12345678,1,0,0,0));
    vq.push_back(mk(0,0,0,0,0,OK,0, ID,32'h2000,1,32'h12345678,1,0,0,0));
    vq.push_back(mk(0,0,0,0,1,OK,0, ID,32'h2000,1,32'h12345678,1,0,0,0));
    // ERROR on first of two pipelined reads
    vq.push_back(mk(1,0,32'h30,0,1,OK,0, ID,32'h2000,1,32'h12345678,1,1,0,0));
    vq.push_back(mk(1,0,32'h34,0,1,OK,0, NS,32'h30,0,32'h12345678,1,0,0,0));
    vq.push_back(mk(0,0,0,0,0,ER,32'hBAD, NS,32'h34,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,1,ER,32'hBAD, ID,32'h34,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,1,OK,0, ID,32'h34,0,0,1,1,0,1));
    vq.push_back(mk(0,0,0,0,1,OK,0, ID,32'h34,0,0,1,1,0,1));
    // RETRY behaves as ERROR
    vq.push_back(mk(1,0,32'h40,0,1,OK,0, ID,32'h34,0,0,1,0,0,0));
    vq.push_back(mk(1,0,32'h44,0,1,OK,0, NS,32'h40,0,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0,0,RT,32'hBAD, NS,32'h44,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,1,RT,32'hBAD, ID,32'h44,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,1,OK,0, ID,32'h44,0,0,1,1,0,1));
    vq.push_back(mk(0,0,0,0,1,OK,0, ID,32'h44,0,0,1,1,0,1));
    // address-phase wait states hold NONSEQ and block accept
    vq.push_back(mk(1,0,32'h50,0,1,OK,0, ID,32'h44,0,0,1,0,0,0));
    vq.push_back(mk(1,0,32'h54,0,0,OK,0, NS,32'h50,0,0,0,0,0,0));
    vq.push_back(mk(1,0,32'h54,0,0,OK,0, NS,32'h50,0,0,0,0,0,0));
    vq.push_back(mk(1,0,32'h54,0,1,OK,0, NS,32'h50,0,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0,1,OK,32'h50, NS,32'h54,0,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0,1,OK,32'h54, ID,32'h54,0,0,1,1,32'h50,0));
    vq.push_back(mk(0,0,0,0,1,OK,0, ID,32'h54,0,0,1,1,32'h54,0));
    vq.push_back(mk(0,0,0,0,1,OK,0, ID,32'h54,0,0,1,0,0,0));

    #10;
    chk("reset_state", {1'b0, reset_vals()}, rst_exp);
    #2 rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      req_valid = vq[i].v;
      req_write = vq[i].w;
      req_size  = SIZE_WORD;
      req_addr  = vq[i].a;
      req_wdata = vq[i].d;
      hready    = vq[i].hr;
      hresp     = vq[i].rs;
      hrdata    = vq[i].rd;
      #1;
      chk($sformatf("row%0d", i), obs(),
          {26'd0, vq[i].et, vq[i].ea, vq[i].ew, vq[i].ed,
           vq[i].ey, vq[i].ev, vq[i].erd, vq[i].ee});
    end

    // reset while the address phase is stalled
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = SIZE_HALF;
    req_addr  = 32'h60;
    req_wdata = 32'hA5A5A5A5;
    hready    = 1'b1;
    hresp     = OK;
    hrdata    = '0;
    #1 chk("mr_accept", {127'd0, req_ready}, 128'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    hready    = 1'b0;
    #1 chk("mr_addr", {93'd0, htrans, haddr, hsize},
           {93'd0, NS, 32'h60, SIZE_HALF});
    #1 rst_n = 1'b0;
    #1 chk("mr_reset_vals", {1'b0, reset_vals()}, rst_exp);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1 chk($sformatf("mr_hold%0d", k),
             {1'b0, reset_vals()}, rst_exp);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    hready = 1'b1;
    #1 chk("mr_ready", {126'd0, req_ready, rsp_valid}, 128'd2);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1 chk($sformatf("mr_quiet%0d", k),
             {125'd0, htrans, rsp_valid}, {125'd0, ID, 1'b0});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
